// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: FSM states and doubleword geometry.
// Imported by the controller and the storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int OFFSET_W = 3;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, combinational read,
// asynchronous clear of every entry.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_memory.sv
// Multi-cycle doubleword data memory: IDLE/BUSY/RESP handshake,
// request validation, and a latched access applied on BUSY->RESP.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        busy,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              store_q, store_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req, bad, accept, done;
  logic              arr_we;
  logic [63:0]       arr_rdata;

  assign req = mem_read | mem_write;
  assign bad = (addr[OFFSET_W-1:0] != '0)
             | (addr[63:AW+OFFSET_W] != '0)
             | (mem_read & mem_write);
  assign accept = (state_q == S_IDLE) & req & ~bad;
  assign done   = (state_q == S_BUSY) & (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: if (done) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are captured only on accept; the access uses the latched copy.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    store_d = store_q;
    rdata_d = rdata_q;
    err_d   = (state_q == S_IDLE) & req & bad;
    arr_we  = done & store_q;
    if (accept) begin
      cnt_d   = CNT_W'(WAIT_CYCLES);
      idx_d   = addr[AW+OFFSET_W-1:OFFSET_W];
      wdata_d = write_data;
      store_d = mem_write;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (done & ~store_q) rdata_d = arr_rdata;
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    ready     = (state_q == S_RESP);
    err       = err_q;
    read_data = rdata_q;
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (reset),
    .we    (arr_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// accesses against a behavioural doubleword-array model.
module tb_data_memory;

  localparam int DEPTH = 64;
  localparam int WA    = 1;
  localparam int WB    = 3;

  logic clk = 1'b0;
  logic reset;

  logic        mem_read, mem_write;
  logic [63:0] addr, write_data, read_data;
  logic        busy, ready, err;

  logic        b_rd, b_wr;
  logic [63:0] b_addr, b_wd, b_rdata;
  logic        b_busy, b_ready, b_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] mdl_mem [DEPTH];
  logic [63:0] mdl_rd;

  always #5 clk = ~clk;

  data_memory #(.DEPTH(DEPTH), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data),
    .read_data(read_data), .busy(busy), .ready(ready), .err(err)
  );

  data_memory #(.DEPTH(DEPTH), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .reset(reset),
    .mem_read(b_rd), .mem_write(b_wr),
    .addr(b_addr), .write_data(b_wd),
    .read_data(b_rdata), .busy(b_busy), .ready(b_ready), .err(b_err)
  );

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    mdl_rd = '0;
  endfunction

  // Requester on instance A: holds the request until ready (or until err
  // is seen), optionally perturbing addr/write_data while the access runs.
  task automatic access(input logic rd, input logic wr,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic perturb,
                        output logic got_err, output logic got_ready,
                        output int lat, output logic [63:0] rdv);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; write_data = wd;
    got_err = 1'b0; got_ready = 1'b0; lat = 0; rdv = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        got_err = err;
        if (err) begin
          mem_read = 1'b0; mem_write = 1'b0;
        end else if (perturb) begin
          write_data = ~wd; addr = a ^ 64'h8;
        end
      end
      if (ready) begin
        got_ready = 1'b1; lat = k; rdv = read_data;
        break;
      end
      if (got_err && k >= 4) break;
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read = 0; mem_write = 0; addr = 0; write_data = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_wd = 0;
    model_clear();
    repeat (3) @(negedge clk);
    total_cnt++;
    if (read_data !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", read_data);
    else pass_cnt++;
    total_cnt++;
    if ({busy, ready, err} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy, ready, err});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, ready, err} !== 3'b000) $display("FAIL post_reset_flags got=%b exp=000", {busy, ready, err});
    else pass_cnt++;
  endtask

  task automatic test_first_load();
    logic e, r; int lat; logic [63:0] v;
    access(1, 0, 64'h40, 0, 0, e, r, lat, v);
    total_cnt++;
    if (!(r === 1'b1 && e === 1'b0 && lat == WA + 1))
      $display("FAIL first_load_latency got=%0d err=%b exp=%0d", lat, e, WA + 1);
    else pass_cnt++;
    total_cnt++;
    if (v !== 64'h0) $display("FAIL first_load_data got=%h exp=0", v);
    else pass_cnt++;
  endtask

  task automatic test_store_load();
    logic e, r; int lat; logic [63:0] v;
    access(0, 1, 64'h08, 64'hDEADBEEF_CAFEF00D, 0, e, r, lat, v);
    mdl_mem[1] = 64'hDEADBEEF_CAFEF00D;
    total_cnt++;
    if (!(r === 1'b1 && lat == WA + 1 && read_data === mdl_rd))
      $display("FAIL store_done got lat=%0d rdata=%h exp lat=%0d rdata=%h", lat, read_data, WA + 1, mdl_rd);
    else pass_cnt++;
    access(1, 0, 64'h08, 0, 0, e, r, lat, v);
    mdl_rd = mdl_mem[1];
    total_cnt++;
    if (!(r === 1'b1 && v === 64'hDEADBEEF_CAFEF00D))
      $display("FAIL store_then_load got=%h exp=deadbeefcafef00d", v);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic e, r; int lat; logic [63:0] v;
    logic [63:0] bad_a [3];
    logic [1:0]  bad_op [3];
    bad_a[0] = 64'h0C;  bad_op[0] = 2'b10;
    bad_a[1] = 64'h200; bad_op[1] = 2'b10;
    bad_a[2] = 64'h08;  bad_op[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      access(bad_op[i][1], bad_op[i][0], bad_a[i], 64'h1234, 0, e, r, lat, v);
      total_cnt++;
      if (!(e === 1'b1 && r === 1'b0 && busy === 1'b0 && read_data === mdl_rd))
        $display("FAIL reject_%0d got err=%b ready=%b busy=%b rdata=%h exp err=1 ready=0 busy=0 rdata=%h",
                 i, e, r, busy, read_data, mdl_rd);
      else pass_cnt++;
    end
    access(1, 0, 64'h08, 0, 0, e, r, lat, v);
    total_cnt++;
    if (v !== mdl_mem[1]) $display("FAIL reject_mem_intact got=%h exp=%h", v, mdl_mem[1]);
    else pass_cnt++;
  endtask

  task automatic test_input_change();
    logic e, r; int lat; logic [63:0] v;
    access(0, 1, 64'h10, 64'h1111, 1, e, r, lat, v);
    mdl_mem[2] = 64'h1111;
    access(1, 0, 64'h10, 0, 1, e, r, lat, v);
    total_cnt++;
    if (v !== 64'h1111) $display("FAIL busy_input_change got=%h exp=1111", v);
    else pass_cnt++;
    access(1, 0, 64'h18, 0, 0, e, r, lat, v);
    mdl_rd = v;
    total_cnt++;
    if (v !== mdl_mem[3]) $display("FAIL neighbour_untouched got=%h exp=%h", v, mdl_mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic e, r; int lat; logic [63:0] v;
    logic [63:0] a, d;
    logic rd, wr, exp_bad;
    int idx, kind;
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 7);
      kind = $urandom_range(0, 11);
      a = 64'(idx) * 8;
      if (kind == 0) a = a + 64'($urandom_range(1, 7));
      if (kind == 1) a = 64'(DEPTH * 8) + 64'($urandom_range(0, 100)) * 8;
      rd = ($urandom_range(0, 1) == 0);
      wr = ~rd;
      if (kind == 2) begin rd = 1; wr = 1; end
      d = {$urandom, $urandom};
      exp_bad = (a % 8 != 0) || (a >= 64'(DEPTH * 8)) || (rd && wr);
      access(rd, wr, a, d, n[0], e, r, lat, v);
      if (!exp_bad && wr) mdl_mem[a / 8] = d;
      if (!exp_bad && rd) mdl_rd = mdl_mem[a / 8];
      total_cnt++;
      if (exp_bad ? !(e === 1'b1 && r === 1'b0)
                  : !(e === 1'b0 && r === 1'b1 && lat == WA + 1))
        $display("FAIL rand_handshake n=%0d a=%h got err=%b ready=%b lat=%0d exp bad=%b lat=%0d",
                 n, a, e, r, lat, exp_bad, WA + 1);
      else pass_cnt++;
      total_cnt++;
      if (read_data !== mdl_rd)
        $display("FAIL rand_rdata n=%0d a=%h got=%h exp=%h", n, a, read_data, mdl_rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic eb, er;
    @(negedge clk);
    b_rd = 1; b_addr = 64'h40;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b_rd = 0; b_wr = 1; b_addr = 64'h48; b_wd = 64'h77;
      end
      eb = (k <= 4) || (k >= 6);
      er = (k == 4) || (k == 9);
      total_cnt++;
      if ({b_busy, b_ready, b_err} !== {eb, er, 1'b0})
        $display("FAIL wait3_cycle_%0d got busy/ready/err=%b exp=%b", k, {b_busy, b_ready, b_err}, {eb, er, 1'b0});
      else pass_cnt++;
    end
    b_wr = 0;
    @(negedge clk);
    b_rd = 1; b_addr = 64'h48;
    @(negedge clk);
    b_rd = 0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (!(b_ready === 1'b1 && b_rdata === 64'h77))
      $display("FAIL wait3_load got ready=%b data=%h exp ready=1 data=77", b_ready, b_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic e, r; int lat; logic [63:0] v;
    logic saw_ready;
    @(negedge clk);
    mem_write = 1; addr = 64'h18; write_data = 64'h55;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL abort_busy got=%b exp=1", busy);
    else pass_cnt++;
    reset = 1'b1;
    mem_write = 0;
    model_clear();
    saw_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_ready = saw_ready | ready;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_ready = saw_ready | ready;
    end
    total_cnt++;
    if (saw_ready !== 1'b0 || read_data !== 64'h0)
      $display("FAIL abort_no_ready got ready_seen=%b rdata=%h exp 0 and 0", saw_ready, read_data);
    else pass_cnt++;
    access(1, 0, 64'h18, 0, 0, e, r, lat, v);
    total_cnt++;
    if (!(r === 1'b1 && v === mdl_mem[3]))
      $display("FAIL abort_no_write got ready=%b data=%h exp ready=1 data=%h", r, v, mdl_mem[3]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_store_load();
    test_errors();
    test_input_change();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
